// File: rtl/bus_rr_nm.sv
// Shared N-master / N-slave bus with a registered arbiter (fixed-priority or
// round-robin, with ownership lock), windowed slave decode and registered read return.
module bus_rr_nm #(
    parameter int N_MASTER = 2,
    parameter int N_SLAVE  = 4,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 64,
    parameter int SLAVE_AW = 10,
    parameter int ARB_MODE = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [N_MASTER-1:0]          m_req,
    input  logic [N_MASTER-1:0]          m_wr,
    input  logic [N_MASTER*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTER*DATA_W-1:0]   m_dout,
    output logic [N_MASTER-1:0]          m_grant,
    output logic [DATA_W-1:0]            m_din,
    output logic                         m_err,
    output logic [N_SLAVE-1:0]           s_sel,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_din,
    output logic                         s_wr,
    input  logic [N_SLAVE*DATA_W-1:0]    s_dout
);

    localparam int LW = $clog2(N_MASTER);
    localparam int IW = ADDR_W - SLAVE_AW;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         owner_q, owner_d, last_q;
    logic [N_MASTER-1:0]   grant_d;
    logic                  new_grant;
    logic                  win_found;
    logic [LW-1:0]         win_idx;

    logic                  owned;
    logic [ADDR_W-1:0]     own_addr;
    logic [DATA_W-1:0]     own_data;
    logic                  own_wr;
    logic [IW-1:0]         slave_idx;
    logic                  mapped;
    logic [DATA_W-1:0]     rdata;

    // Candidate visited at search step k: plain index order, or rotating from last_owner+1.
    function automatic logic [LW-1:0] arb_cand(input logic [LW-1:0] base, input int k);
        int c;
        if (ARB_MODE == 0) begin
            c = k;
        end else begin
            c = int'(base) + 1 + k;
            if (c >= N_MASTER) c = c - N_MASTER;
        end
        return LW'(c);
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N_MASTER; k++) begin
            if (!win_found && m_req[arb_cand(last_q, k)]) begin
                win_found = 1'b1;
                win_idx   = arb_cand(last_q, k);
            end
        end
    end

    // A dropping owner has m_req low, so it can never win its own re-arbitration.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        new_grant = 1'b0;
        grant_d   = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d   = OWNED;
                    owner_d   = win_idx;
                    new_grant = 1'b1;
                end
            end
            OWNED: begin
                if (!m_req[owner_q]) begin
                    if (win_found) begin
                        owner_d   = win_idx;
                        new_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == OWNED) grant_d[owner_d] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= LW'(N_MASTER - 1);
            m_grant <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers sample together.
            state_q <= state_d;
            owner_q <= owner_d;
            m_grant <= grant_d;
            if (new_grant) last_q <= owner_d;
        end
    end

    assign owned     = (state_q == OWNED);
    assign own_addr  = m_addr[int'(owner_q)*ADDR_W +: ADDR_W];
    assign own_data  = m_dout[int'(owner_q)*DATA_W +: DATA_W];
    assign own_wr    = m_wr[owner_q];
    assign slave_idx = own_addr[ADDR_W-1:SLAVE_AW];
    assign mapped    = int'(slave_idx) < N_SLAVE;

    always_comb begin
        s_sel = '0;
        rdata = '0;
        for (int k = 0; k < N_SLAVE; k++) begin
            if (owned && int'(slave_idx) == k) begin
                s_sel[k] = 1'b1;
                rdata    = s_dout[k*DATA_W +: DATA_W];
            end
        end
    end

    assign s_wr   = owned && own_wr && mapped;
    assign s_addr = owned ? own_addr : '0;
    assign s_din  = owned ? own_data : '0;

    // Unmapped accesses return zero data and raise m_err in the following cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_din <= '0;
            m_err <= 1'b0;
        end else begin
            m_din <= (owned && !own_wr && mapped) ? rdata : '0;
            m_err <= owned && !mapped;
        end
    end

endmodule
